// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic light sequencer: state encodings,
// lamp codes and the phase timer width.
package tlc_pkg;

    localparam int TIMER_W = 7;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_1 = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_2 = 3'd5,
        WALK      = 3'd6,
        FLASH     = 3'd7
    } tlc_state_e;

    // Lamp codes are {red, yellow, green}.
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
    } lamps_t;

endpackage

// File: rtl/tlc_tick_gen.sv
// Prescaler producing a single-cycle tick every CLK_PER_TICK clock cycles.
// The first tick falls on the CLK_PER_TICK-th edge after reset release.
module tlc_tick_gen #(
    parameter int CLK_PER_TICK = 10000000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int              CNT_W = $clog2(CLK_PER_TICK);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_TICK - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of its peers, exactly as the hardware does.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_light_sequencer.sv
// Moore sequencer for a two-way intersection with a latched pedestrian phase.
// Optional night flashing mode is built when TLC_NIGHT_FLASH_EN is defined.
module traffic_light_sequencer
    import tlc_pkg::*;
#(
    parameter int CLK_PER_TICK = 10000000,
    parameter int GREEN_TICKS  = 100,
    parameter int YELLOW_TICKS = 30,
    parameter int ALLRED_TICKS = 10,
    parameter int WALK_TICKS   = 70
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ped_req,
`ifdef TLC_NIGHT_FLASH_EN
    input  logic               night_mode,
`endif
    output logic [2:0]         ns_light,
    output logic [2:0]         ew_light,
    output logic               walk,
    output logic               ped_pending,
    output logic [TIMER_W-1:0] phase_time,
    output logic [2:0]         state
);

    localparam logic [TIMER_W-1:0] GREEN_LAST  = TIMER_W'(GREEN_TICKS - 1);
    localparam logic [TIMER_W-1:0] YELLOW_LAST = TIMER_W'(YELLOW_TICKS - 1);
    localparam logic [TIMER_W-1:0] ALLRED_LAST = TIMER_W'(ALLRED_TICKS - 1);
    localparam logic [TIMER_W-1:0] WALK_LAST   = TIMER_W'(WALK_TICKS - 1);
`ifdef TLC_NIGHT_FLASH_EN
    // Flash period is ten ticks: lamp lit for the first five.
    localparam logic [TIMER_W-1:0] FLASH_LAST = TIMER_W'(9);
    localparam logic [TIMER_W-1:0] FLASH_LIT  = TIMER_W'(5);
`endif

    tlc_state_e         state_q, state_d, adv_state;
    logic [TIMER_W-1:0] phase_q, phase_d, phase_last;
    logic               pend_q, pend_d;
    logic               legal;
    logic               tick;
    lamps_t             lamps;

    tlc_tick_gen #(
        .CLK_PER_TICK(CLK_PER_TICK)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= NS_GREEN;
            phase_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pend_q  <= pend_d;
        end
    end

    // NOTE: every variable written here gets a default before any branch, so
    // no path can leave one unassigned and infer a latch.
    always_comb begin
        adv_state  = NS_YELLOW;
        phase_last = '0;
        legal      = 1'b1;
        lamps      = '{ns: OFF, ew: OFF, walk: 1'b0};

        case (state_q)
            NS_GREEN: begin
                phase_last = GREEN_LAST;
                adv_state  = NS_YELLOW;
                lamps.ns   = GRN;
                lamps.ew   = RED;
            end
            NS_YELLOW: begin
                phase_last = YELLOW_LAST;
                adv_state  = ALL_RED_1;
                lamps.ns   = YEL;
                lamps.ew   = RED;
            end
            ALL_RED_1: begin
                phase_last = ALLRED_LAST;
                adv_state  = EW_GREEN;
`ifdef TLC_NIGHT_FLASH_EN
                if (night_mode) adv_state = FLASH;
`endif
                lamps.ns   = RED;
                lamps.ew   = RED;
            end
            EW_GREEN: begin
                phase_last = GREEN_LAST;
                adv_state  = EW_YELLOW;
                lamps.ns   = RED;
                lamps.ew   = GRN;
            end
            EW_YELLOW: begin
                phase_last = YELLOW_LAST;
                adv_state  = ALL_RED_2;
                lamps.ns   = RED;
                lamps.ew   = YEL;
            end
            ALL_RED_2: begin
                phase_last = ALLRED_LAST;
                adv_state  = pend_q ? WALK : NS_GREEN;
`ifdef TLC_NIGHT_FLASH_EN
                if (night_mode) adv_state = FLASH;
`endif
                lamps.ns   = RED;
                lamps.ew   = RED;
            end
            WALK: begin
                phase_last = WALK_LAST;
                adv_state  = NS_GREEN;
                lamps.ns   = RED;
                lamps.ew   = RED;
                lamps.walk = 1'b1;
            end
`ifdef TLC_NIGHT_FLASH_EN
            FLASH: begin
                phase_last = FLASH_LAST;
                adv_state  = night_mode ? FLASH : ALL_RED_2;
                if (phase_q < FLASH_LIT) begin
                    lamps.ns = YEL;
                    lamps.ew = RED;
                end
            end
`endif
            default: begin
                // Unknown encoding: show all red and recover through yellow.
                legal    = 1'b0;
                lamps.ns = RED;
                lamps.ew = RED;
            end
        endcase

        state_d = state_q;
        phase_d = phase_q;
        pend_d  = pend_q | ped_req;

        if (!legal) begin
            state_d = NS_YELLOW;
            phase_d = '0;
        end else if (tick) begin
            if (phase_q == phase_last) begin
                state_d = adv_state;
                phase_d = '0;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end

        // Entering WALK serves the request, even if the button is still held.
        if (state_d == WALK && state_q != WALK) begin
            pend_d = 1'b0;
        end
    end

    assign ns_light    = lamps.ns;
    assign ew_light    = lamps.ew;
    assign walk        = lamps.walk;
    assign ped_pending = pend_q;
    assign phase_time  = phase_q;
    assign state       = state_q;

    a_no_green_conflict: assert property (@(posedge clk) disable iff (!reset)
        !(ns_light == GRN && ew_light == GRN));
    a_walk_all_red: assert property (@(posedge clk) disable iff (!reset)
        walk |-> (ns_light == RED && ew_light == RED));
    a_lamps_onehot: assert property (@(posedge clk) disable iff (!reset)
        $onehot0(ns_light) && $onehot0(ew_light));
    a_phase_bound: assert property (@(posedge clk) disable iff (!reset)
        legal |-> (phase_q <= phase_last));

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Self-checking bench: phase-table model compared every cycle, plus directed
// literal checks at hand-computed edges.
module tb_traffic_light_sequencer;
    import tlc_pkg::*;

    localparam int CPT = 4;
    localparam int G   = 5;
    localparam int Y   = 3;
    localparam int AR  = 2;
    localparam int W   = 4;
`ifdef TLC_NIGHT_FLASH_EN
    localparam bit NIGHT_BUILD = 1'b1;
`else
    localparam bit NIGHT_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ped_req = 1'b0;
    logic       night_mode = 1'b0;
    logic [2:0] ns_light, ew_light, state;
    logic       walk, ped_pending;
    logic [6:0] phase_time;

    int n_cmp = 0;
    int n_err = 0;
    int cur = 0;
    bit chk_en = 1'b1;
    bit inj_illegal = 1'b0;

    always #5 clk = ~clk;

    traffic_light_sequencer #(
        .CLK_PER_TICK(CPT),
        .GREEN_TICKS (G),
        .YELLOW_TICKS(Y),
        .ALLRED_TICKS(AR),
        .WALK_TICKS  (W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ped_req    (ped_req),
`ifdef TLC_NIGHT_FLASH_EN
        .night_mode (night_mode),
`endif
        .ns_light   (ns_light),
        .ew_light   (ew_light),
        .walk       (walk),
        .ped_pending(ped_pending),
        .phase_time (phase_time),
        .state      (state)
    );

    // Phase table: 0 NS green, 1 NS yellow, 2 all red, 3 EW green,
    // 4 EW yellow, 5 all red, 6 walk, 7 flash.
    function automatic int dur(input int s);
        case (s)
            0, 3:    return G;
            1, 4:    return Y;
            2, 5:    return AR;
            6:       return W;
            default: return 10;
        endcase
    endfunction

    function automatic int succ(input int s, input bit pend, input bit night);
        case (s)
            0:       return 1;
            1:       return 2;
            2:       return night ? 7 : 3;
            3:       return 4;
            4:       return 5;
            5:       return night ? 7 : (pend ? 6 : 0);
            6:       return 0;
            default: return night ? 7 : 5;
        endcase
    endfunction

    // {ns, ew, walk}
    function automatic logic [6:0] lamps_of(input int s, input int pt);
        case (s)
            0:       return {3'b001, 3'b100, 1'b0};
            1:       return {3'b010, 3'b100, 1'b0};
            3:       return {3'b100, 3'b001, 1'b0};
            4:       return {3'b100, 3'b010, 1'b0};
            6:       return {3'b100, 3'b100, 1'b1};
            7:       return (pt < 5) ? {3'b010, 3'b100, 1'b0} : 7'b0;
            default: return {3'b100, 3'b100, 1'b0};
        endcase
    endfunction

    function automatic logic [17:0] pk(input logic [2:0] ns, input logic [2:0] ew,
                                       input logic wk, input logic pd,
                                       input logic [6:0] pt, input logic [2:0] st);
        return {ns, ew, wk, pd, pt, st};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model
    int   m_cnt, m_state, m_pt;
    bit   m_pend;
    logic m_night, m_tick, m_end;
    int   m_nxt;

    assign m_night = night_mode && NIGHT_BUILD;
    assign m_tick  = (m_cnt == CPT - 1);
    assign m_end   = m_tick && (m_pt == dur(m_state) - 1);
    assign m_nxt   = succ(m_state, m_pend, m_night);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt   <= 0;
            m_state <= 0;
            m_pt    <= 0;
            m_pend  <= 1'b0;
        end else begin
            m_cnt  <= (m_cnt + 1) % CPT;
            m_pend <= (!inj_illegal && m_end && m_nxt == 6) ? 1'b0 : (m_pend | ped_req);
            if (inj_illegal) begin
                m_state <= 1;
                m_pt    <= 0;
            end else if (m_end) begin
                m_state <= m_nxt;
                m_pt    <= 0;
            end else if (m_tick) begin
                m_pt <= m_pt + 1;
            end
        end
    end

    logic [17:0] dut_out;
    assign dut_out = {ns_light, ew_light, walk, ped_pending, phase_time, state};

    always @(negedge clk) begin
        if (reset && chk_en)
            check("cycle", 32'(dut_out),
                  32'({lamps_of(m_state, m_pt), m_pend, 7'(m_pt), 3'(m_state)}));
    end

    task automatic run_to(input int e);
        repeat (e - cur) @(negedge clk);
        cur = e;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        ped_req = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        cur = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_state", 32'(dut_out), 32'(pk(3'b001, 3'b100, 0, 0, 0, 0)));
        #2 reset = 1'b1;
        cur = 0;

        // No pedestrian: full NS/EW cycle.
        run_to(19);
        check("e19_ns_green", 32'(dut_out), 32'(pk(3'b001, 3'b100, 0, 0, 4, 0)));
        run_to(20);
        check("e20_ns_yellow", 32'(dut_out), 32'(pk(3'b010, 3'b100, 0, 0, 0, 1)));
        check("e20_model", 32'(m_state), 32'd1);
        run_to(32);
        check("e32_all_red_1", 32'(dut_out), 32'(pk(3'b100, 3'b100, 0, 0, 0, 2)));
        run_to(40);
        check("e40_ew_green", 32'(dut_out), 32'(pk(3'b100, 3'b001, 0, 0, 0, 3)));
        run_to(79);
        check("e79_all_red_2", 32'(dut_out), 32'(pk(3'b100, 3'b100, 0, 0, 1, 5)));
        run_to(80);
        check("e80_ns_green", 32'(dut_out), 32'(pk(3'b001, 3'b100, 0, 0, 0, 0)));

        // Single-cycle pedestrian pulse.
        do_reset();
        run_to(10);
        ped_req = 1'b1;
        run_to(11);
        ped_req = 1'b0;
        check("e11_pending", 32'(ped_pending), 32'd1);
        run_to(80);
        check("e80_walk", 32'(dut_out), 32'(pk(3'b100, 3'b100, 1, 0, 0, 6)));
        check("e80_model_walk", 32'(m_state), 32'd6);
        run_to(95);
        check("e95_walk_end", 32'(dut_out), 32'(pk(3'b100, 3'b100, 1, 0, 3, 6)));
        run_to(96);
        check("e96_ns_green", 32'(dut_out), 32'(pk(3'b001, 3'b100, 0, 0, 0, 0)));

        // Button held: served on entry, re-latched one edge later.
        do_reset();
        ped_req = 1'b1;
        run_to(80);
        check("held_e80_clear", 32'(dut_out), 32'(pk(3'b100, 3'b100, 1, 0, 0, 6)));
        run_to(81);
        check("held_e81_relatch", 32'(ped_pending), 32'd1);
        run_to(96);
        check("held_e96_ns_green", 32'(state), 32'd0);
        run_to(176);
        check("held_e176_walk", 32'(dut_out), 32'(pk(3'b100, 3'b100, 1, 0, 0, 6)));
        ped_req = 1'b0;

        // Reset in the middle of EW green discards a pending request.
        do_reset();
        run_to(10);
        ped_req = 1'b1;
        run_to(11);
        ped_req = 1'b0;
        run_to(45);
        check("e45_ew_green", 32'(dut_out), 32'(pk(3'b100, 3'b001, 0, 1, 1, 3)));
        #2 reset = 1'b0;
        #1 check("mid_reset", 32'(dut_out), 32'(pk(3'b001, 3'b100, 0, 0, 0, 0)));
        @(negedge clk);
        #2 reset = 1'b1;
        cur = 0;

        // Illegal encoding recovers through NS yellow on the next edge.
        run_to(30);
        check("pre_illegal", 32'(state), 32'd1);
        #2 chk_en = 1'b0;
        inj_illegal = 1'b1;
        force dut.state_q = FLASH;
        #1 release dut.state_q;
        #1;
        if (!NIGHT_BUILD)
            check("illegal_all_red", 32'({ns_light, ew_light, walk}), 32'({3'b100, 3'b100, 1'b0}));
        @(posedge clk);
        #1 inj_illegal = 1'b0;
        chk_en = 1'b1;
        if (!NIGHT_BUILD)
            check("illegal_recover", 32'({state, phase_time}), 32'({3'd1, 7'd0}));
        @(negedge clk);
        cur = 31;
        run_to(60);

`ifdef TLC_NIGHT_FLASH_EN
        // Night flashing entered at the end of the first all-red.
        do_reset();
        night_mode = 1'b1;
        run_to(40);
        check("night_e40_flash", 32'(dut_out), 32'(pk(3'b010, 3'b100, 0, 0, 0, 7)));
        run_to(60);
        check("night_e60_dark", 32'(dut_out), 32'(pk(3'b000, 3'b000, 0, 0, 5, 7)));
        run_to(80);
        check("night_e80_lit", 32'(dut_out), 32'(pk(3'b010, 3'b100, 0, 0, 0, 7)));
        run_to(85);
        night_mode = 1'b0;
        run_to(119);
        check("night_e119", 32'(dut_out), 32'(pk(3'b000, 3'b000, 0, 0, 9, 7)));
        run_to(120);
        check("night_e120_exit", 32'(state), 32'd5);
        run_to(128);
        check("night_e128_ns_green", 32'(state), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/traffic_light_sequencer.md
Name: traffic_light_sequencer

Overview:
- Moore FSM sequencing a two-way intersection: north-south (NS), east-west (EW) and a pedestrian walk phase.
- Phase durations are counted in 0.1 s ticks from an internal prescaler.
- The elapsed tenths of the current phase are exported for the seven-segment display logic.
- Sits between board inputs (button, switch) and the light/LED output drivers.

Parameters:
- CLK_PER_TICK, 10000000: clk cycles per 0.1 s tick (100 MHz board); legal range ≥2.
- GREEN_TICKS, 100: green duration in ticks; legal range 1..127.
- YELLOW_TICKS, 30: yellow duration; 1..127.
- ALLRED_TICKS, 10: all-red clearance; 1..127.
- WALK_TICKS, 70: pedestrian walk duration; 1..127.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- ped_req  input  1  pedestrian button, already synchronised and debounced, level
- ns_light  output  3  {red, yellow, green}, one-hot
- ew_light  output  3  {red, yellow, green}, one-hot
- walk  output  1  walk lamp
- ped_pending  output  1  latched pedestrian request
- phase_time  output  7  ticks elapsed in current phase
- state  output  3  current state encoding (debug)

Behaviour:
- Reset (reset=0, async):
  - state=NS_GREEN, phase_time=0, prescaler=0, ped_pending=0.
  - Outputs: ns_light=001, ew_light=100, walk=0.
- Prescaler:
  - Counts 0..CLK_PER_TICK-1 and wraps.
  - tick=1 for the single cycle in which the count equals CLK_PER_TICK-1.
  - First tick occurs on the CLK_PER_TICK-th edge after reset release.
- Phase timer:
  - On tick, if phase_time==DUR(state)-1: advance state and set phase_time=0 on the same edge.
  - Otherwise on tick: phase_time+1.
  - No tick: phase_time holds.
  - phase_time never reaches DUR(state).
- States, in order:
  - NS_GREEN (ns=001, ew=100), GREEN_TICKS → NS_YELLOW.
  - NS_YELLOW (ns=010, ew=100), YELLOW_TICKS → ALL_RED_1.
  - ALL_RED_1 (both 100), ALLRED_TICKS → EW_GREEN.
  - EW_GREEN (ns=100, ew=001), GREEN_TICKS → EW_YELLOW.
  - EW_YELLOW (ns=100, ew=010), YELLOW_TICKS → ALL_RED_2.
  - ALL_RED_2 (both 100), ALLRED_TICKS → WALK if ped_pending, else NS_GREEN.
  - WALK (both 100, walk=1), WALK_TICKS → NS_GREEN.
- Outputs are decoded combinationally from the state register: zero latency relative to the state change; no green ever adjacent to a conflicting green.
- ped_pending:
  - Set on any cycle with ped_req=1.
  - Cleared on the edge that enters WALK. Clear beats set on that edge; ped_req held through the entry edge is treated as served.
  - ped_req during WALK re-latches for the next cycle.
- Illegal state encodings → NS_YELLOW on the next edge (fail-safe towards red).
- Reset mid-phase: immediate return to reset values; the pending request is discarded.

Optional Feature:
- Macro: TLC_NIGHT_FLASH_EN.
- Defined:
  - Adds input night_mode (1 bit) and state FLASH.
  - At the end of ALL_RED_1 or ALL_RED_2, night_mode=1 → FLASH. This takes priority over EW_GREEN, WALK and NS_GREEN.
  - In FLASH: ns yellow and ew red blink together; lamp toggles every 5 ticks, starting lit. Off-phase outputs are ns_light=000, ew_light=000. phase_time counts 0..9 and wraps.
  - Exit only at phase_time wrap with night_mode=0 → ALL_RED_2.
  - ped_pending still latches; walk=0.
- Undefined: no night_mode port, no FLASH state; behaviour exactly as above.

Decomposition:
- Package tlc_pkg holds:
  - state encodings NS_GREEN=0, NS_YELLOW=1, ALL_RED_1=2, EW_GREEN=3, EW_YELLOW=4, ALL_RED_2=5, WALK=6, FLASH=7;
  - light constants RED=3'b100, YEL=3'b010, GRN=3'b001, OFF=3'b000;
  - timer width 7.
- One sub-module, tlc_tick_gen: parameterised prescaler, clk/reset in, tick out.

Test Plan (CLK_PER_TICK=4, GREEN=5, YELLOW=3, ALLRED=2, WALK=4):
- Release reset, ped_req=0 → NS_GREEN until edge 20, NS_YELLOW at edge 20, ALL_RED_1 at 32, EW_GREEN at 40, NS_GREEN again at edge 80. phase_time increments every 4 edges.
- Pulse ped_req for 1 cycle at edge 10 → ped_pending=1 from edge 11; WALK entered at edge 80 with walk=1 and ped_pending=0; NS_GREEN at edge 96.
- ped_req held high continuously → ped_pending re-latches on edge 81; WALK recurs every 96 edges.
- Assert reset at edge 45 (EW_GREEN, phase_time=1) → outputs immediately ns=001, ew=100, phase_time=0, ped_pending=0.
- Force an illegal state of 7 (macro undefined) → NS_YELLOW on the next edge.
- TLC_NIGHT_FLASH_EN defined, night_mode=1 from edge 0 → FLASH at edge 40; ns yellow lit for 20 edges then off for 20. Drop night_mode → ALL_RED_2 at the next wrap, then NS_GREEN.
